// File: rtl/line_cmd_sequencer_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// line_cmd_sequencer_if : valid/ready line-draw command bus (endpoints + colour)
// Rev 1.0
// ----------------------------------------------------------------------------
interface line_cmd_sequencer_if #(
    parameter int CW = 3
);
    logic          cmd_valid;
    logic          cmd_ready;
    logic [10:0]   cmd_x0;
    logic [10:0]   cmd_y0;
    logic [10:0]   cmd_x1;
    logic [10:0]   cmd_y1;
    logic [CW-1:0] cmd_color;

    modport master (
        output cmd_valid, cmd_x0, cmd_y0, cmd_x1, cmd_y1, cmd_color,
        input  cmd_ready
    );

    modport slave (
        input  cmd_valid, cmd_x0, cmd_y0, cmd_x1, cmd_y1, cmd_color,
        output cmd_ready
    );
endinterface
`default_nettype wire

// File: rtl/line_cmd_sequencer.sv
`default_nettype none
// ----------------------------------------------------------------------------
// line_cmd_sequencer : buffers line commands and sequences line_drawer,
//                      emitting one framebuffer write per drawn pixel.
// Rev 1.0
// ----------------------------------------------------------------------------
module line_cmd_sequencer #(
    parameter int DEPTH = 4,
    parameter int CW    = 3
) (
    input  wire logic          clk,
    input  wire logic          reset,
    line_cmd_sequencer_if.slave cmd,
    output logic               ld_reset,
    output logic [10:0]        ld_x0,
    output logic [10:0]        ld_y0,
    output logic [10:0]        ld_x1,
    output logic [10:0]        ld_y1,
    input  wire logic [10:0]   ld_x,
    input  wire logic [10:0]   ld_y,
    output logic [10:0]        pixel_x,
    output logic [10:0]        pixel_y,
    output logic [CW-1:0]      pixel_color,
    output logic               pixel_we,
    output logic               line_done,
    output logic               busy
);
    localparam int              c_AW        = $clog2(DEPTH);
    localparam int              c_EW        = 44 + CW;
    localparam logic [c_AW:0]   c_DEPTH_CNT = DEPTH[c_AW:0];

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_DRAW = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;

    logic [c_EW-1:0]  r_mem [DEPTH];
    logic [c_AW-1:0]  r_wr_ptr;
    logic [c_AW-1:0]  r_rd_ptr;
    logic [c_AW:0]    r_count;

    logic             w_full;
    logic             w_push;
    logic             w_pop;

    logic [10:0]      r_wx0, r_wy0, r_wx1, r_wy1;
    logic [CW-1:0]    r_wcol;
    logic [10:0]      r_cnt;

    logic [10:0]      w_hx0, w_hy0, w_hx1, w_hy1;
    logic [CW-1:0]    w_hcol;
    logic [10:0]      w_dx, w_dy, w_cnt_init;

    assign w_full        = (r_count == c_DEPTH_CNT);
    assign cmd.cmd_ready = !w_full;
    assign w_push        = cmd.cmd_valid && !w_full;

    assign {w_hx0, w_hy0, w_hx1, w_hy1, w_hcol} = r_mem[r_rd_ptr];

    // Completion is by pixel count, so the drawer's traversal direction is irrelevant.
    assign w_dx       = (w_hx1 >= w_hx0) ? (w_hx1 - w_hx0) : (w_hx0 - w_hx1);
    assign w_dy       = (w_hy1 >= w_hy0) ? (w_hy1 - w_hy0) : (w_hy0 - w_hy1);
    assign w_cnt_init = (w_dx >= w_dy) ? w_dx : w_dy;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= {cmd.cmd_x0, cmd.cmd_y0, cmd.cmd_x1, cmd.cmd_y1, cmd.cmd_color};
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_pop       = 1'b0;
        ld_reset    = 1'b1;
        pixel_we    = 1'b0;
        line_done   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (r_count != '0) begin
                    w_pop       = 1'b1;
                    w_state_nxt = S_LOAD;
                end
            end
            S_LOAD: begin
                w_state_nxt = S_DRAW;
            end
            S_DRAW: begin
                ld_reset = 1'b0;
                pixel_we = 1'b1;
                if (r_cnt == '0) begin
                    line_done   = 1'b1;
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wx0  <= '0;
            r_wy0  <= '0;
            r_wx1  <= '0;
            r_wy1  <= '0;
            r_wcol <= '0;
            r_cnt  <= '0;
        end else if (w_pop) begin
            r_wx0  <= w_hx0;
            r_wy0  <= w_hy0;
            r_wx1  <= w_hx1;
            r_wy1  <= w_hy1;
            r_wcol <= w_hcol;
            r_cnt  <= w_cnt_init;
        end else if (r_state == S_DRAW && r_cnt != '0) begin
            r_cnt <= r_cnt - 1'b1;
        end
    end

    assign ld_x0       = r_wx0;
    assign ld_y0       = r_wy0;
    assign ld_x1       = r_wx1;
    assign ld_y1       = r_wy1;
    assign pixel_color = r_wcol;
    assign pixel_x     = ld_x;
    assign pixel_y     = ld_y;
    assign busy        = (r_state != S_IDLE) || (r_count != '0);

endmodule
`default_nettype wire

// File: tb/tb_line_cmd_sequencer.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_line_cmd_sequencer : directed bench with a line_drawer stub that replays
//                         a per-line pixel table or walks +x from (x0,y0).
// Rev 1.0
// ----------------------------------------------------------------------------
module tb_line_cmd_sequencer;
    localparam int CW = 3;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    line_cmd_sequencer_if #(.CW(CW)) cmd_if();

    logic          ld_reset;
    logic [10:0]   ld_x0, ld_y0, ld_x1, ld_y1;
    logic [10:0]   ld_x, ld_y;
    logic [10:0]   pixel_x, pixel_y;
    logic [CW-1:0] pixel_color;
    logic          pixel_we, line_done, busy;

    line_cmd_sequencer #(.DEPTH(4), .CW(CW)) dut (
        .clk         (clk),
        .reset       (reset),
        .cmd         (cmd_if),
        .ld_reset    (ld_reset),
        .ld_x0       (ld_x0),
        .ld_y0       (ld_y0),
        .ld_x1       (ld_x1),
        .ld_y1       (ld_y1),
        .ld_x        (ld_x),
        .ld_y        (ld_y),
        .pixel_x     (pixel_x),
        .pixel_y     (pixel_y),
        .pixel_color (pixel_color),
        .pixel_we    (pixel_we),
        .line_done   (line_done),
        .busy        (busy)
    );

    // Drawer stub: step index restarts while ld_reset is high.
    logic [7:0]       stub_idx = '0;
    logic             use_tab  = 1'b0;
    logic [7:0][10:0] tab_x    = '0;
    logic [7:0][10:0] tab_y    = '0;

    always @(posedge clk) stub_idx <= ld_reset ? 8'd0 : stub_idx + 8'd1;

    always_comb begin
        if (use_tab) begin
            ld_x = tab_x[stub_idx[2:0]];
            ld_y = tab_y[stub_idx[2:0]];
        end else begin
            ld_x = ld_x0 + {3'b000, stub_idx};
            ld_y = ld_y0;
        end
    end

    typedef struct packed {
        logic [10:0]      x0;
        logic [10:0]      y0;
        logic [10:0]      x1;
        logic [10:0]      y1;
        logic [2:0]       col;
        logic [7:0]       n;
        logic [7:0][10:0] px;
        logic [7:0][10:0] py;
    } vec_t;

    vec_t vecs [4];
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic vec_t mk(input int x0, input int y0, input int x1, input int y1,
                                input int col, input int n);
        vec_t v;
        v     = '0;
        v.x0  = x0[10:0];
        v.y0  = y0[10:0];
        v.x1  = x1[10:0];
        v.y1  = y1[10:0];
        v.col = col[2:0];
        v.n   = n[7:0];
        return v;
    endfunction

    function automatic void sp(input int v, input int i, input int x, input int y);
        vecs[v].px[i] = x[10:0];
        vecs[v].py[i] = y[10:0];
    endfunction

    task automatic drive_cmd(input vec_t v, input logic vld);
        cmd_if.cmd_valid = vld;
        cmd_if.cmd_x0    = v.x0;
        cmd_if.cmd_y0    = v.y0;
        cmd_if.cmd_x1    = v.x1;
        cmd_if.cmd_y1    = v.y1;
        cmd_if.cmd_color = v.col;
    endtask

    // Starts at the negedge of the IDLE pop cycle, ends at the negedge after the last DRAW.
    task automatic expect_line(input vec_t v, input bit tab, input bit chk_rdy);
        logic [31:0] ex, ey;
        use_tab = tab;
        tab_x   = v.px;
        tab_y   = v.py;
        chk("idle_we", {31'd0, pixel_we}, 32'd0);
        chk("idle_ldrst", {31'd0, ld_reset}, 32'd1);
        chk("idle_busy", {31'd0, busy}, 32'd1);
        @(negedge clk);
        cmd_if.cmd_valid = 1'b0;
        chk("load_ldrst", {31'd0, ld_reset}, 32'd1);
        chk("load_we", {31'd0, pixel_we}, 32'd0);
        chk("load_x0", {21'd0, ld_x0}, {21'd0, v.x0});
        chk("load_y0", {21'd0, ld_y0}, {21'd0, v.y0});
        chk("load_x1", {21'd0, ld_x1}, {21'd0, v.x1});
        chk("load_y1", {21'd0, ld_y1}, {21'd0, v.y1});
        chk("load_col", {29'd0, pixel_color}, {29'd0, v.col});
        if (chk_rdy) chk("load_ready", {31'd0, cmd_if.cmd_ready}, 32'd1);
        for (int i = 0; i < int'(v.n); i++) begin
            @(negedge clk);
            if (tab) begin
                ex = {21'd0, v.px[i]};
                ey = {21'd0, v.py[i]};
            end else begin
                ex = 32'(v.x0) + 32'(i);
                ey = {21'd0, v.y0};
            end
            chk("draw_we", {31'd0, pixel_we}, 32'd1);
            chk("draw_ldrst", {31'd0, ld_reset}, 32'd0);
            chk("draw_x", {21'd0, pixel_x}, ex);
            chk("draw_y", {21'd0, pixel_y}, ey);
            chk("draw_col", {29'd0, pixel_color}, {29'd0, v.col});
            chk("draw_done", {31'd0, line_done}, (i == int'(v.n) - 1) ? 32'd1 : 32'd0);
        end
        @(negedge clk);
    endtask

    task automatic run_line(input vec_t v, input bit tab);
        drive_cmd(v, 1'b1);
        chk("accept_ready", {31'd0, cmd_if.cmd_ready}, 32'd1);
        @(negedge clk);
        cmd_if.cmd_valid = 1'b0;
        expect_line(v, tab, 1'b0);
        chk("end_we", {31'd0, pixel_we}, 32'd0);
        chk("end_done", {31'd0, line_done}, 32'd0);
        chk("end_busy", {31'd0, busy}, 32'd0);
    endtask

    vec_t lng, va, vb, lm, m1, m2;
    vec_t q [5];
    int   acc, npix;
    bit   seen;

    initial begin
        vecs[0] = mk(0, 0, 3, 0, 5, 4);
        sp(0, 0, 0, 0); sp(0, 1, 1, 0); sp(0, 2, 2, 0); sp(0, 3, 3, 0);
        vecs[1] = mk(3, 3, 0, 0, 2, 4);
        sp(1, 0, 0, 0); sp(1, 1, 1, 1); sp(1, 2, 2, 2); sp(1, 3, 3, 3);
        vecs[2] = mk(0, 0, 2, 5, 7, 6);
        sp(2, 0, 0, 0); sp(2, 1, 1, 1); sp(2, 2, 1, 2);
        sp(2, 3, 1, 3); sp(2, 4, 2, 4); sp(2, 5, 2, 5);
        vecs[3] = mk(6, 6, 6, 6, 1, 1);
        sp(3, 0, 6, 6);

        drive_cmd('0, 1'b0);
        #1 reset = 1'b0;
        repeat (3) begin
            @(negedge clk);
            cmd_if.cmd_valid = 1'b1;
            cmd_if.cmd_x0    = 11'($urandom);
            cmd_if.cmd_y0    = 11'($urandom);
            cmd_if.cmd_x1    = 11'($urandom);
            cmd_if.cmd_y1    = 11'($urandom);
            cmd_if.cmd_color = 3'($urandom);
            #1;
            chk("rst_we", {31'd0, pixel_we}, 32'd0);
            chk("rst_done", {31'd0, line_done}, 32'd0);
            chk("rst_busy", {31'd0, busy}, 32'd0);
            chk("rst_ready", {31'd0, cmd_if.cmd_ready}, 32'd1);
            chk("rst_ldrst", {31'd0, ld_reset}, 32'd1);
            chk("rst_x0", {21'd0, ld_x0}, 32'd0);
            chk("rst_y1", {21'd0, ld_y1}, 32'd0);
            chk("rst_col", {29'd0, pixel_color}, 32'd0);
        end
        @(negedge clk);
        cmd_if.cmd_valid = 1'b0;
        reset = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("post_rst_we", {31'd0, pixel_we}, 32'd0);
            chk("post_rst_busy", {31'd0, busy}, 32'd0);
            chk("post_rst_ready", {31'd0, cmd_if.cmd_ready}, 32'd1);
        end

        for (int k = 0; k < 4; k++) run_line(vecs[k], 1'b1);

        // FIFO fill behind a 100-pixel line
        lng = mk(0, 0, 99, 0, 3, 100);
        for (int j = 0; j < 5; j++) q[j] = mk(10 * (j + 1), j + 1, 10 * (j + 1) + 1, j + 1, j + 1, 2);
        use_tab = 1'b0;
        drive_cmd(lng, 1'b1);
        @(negedge clk);
        acc  = 0;
        npix = 0;
        for (int c = 0; c < 10; c++) begin
            if (acc < 5) drive_cmd(q[acc], 1'b1);
            if (pixel_we) npix++;
            if (cmd_if.cmd_ready) acc++;
            @(negedge clk);
        end
        cmd_if.cmd_valid = 1'b0;
        chk("full_accepts", 32'(acc), 32'd4);
        chk("full_ready", {31'd0, cmd_if.cmd_ready}, 32'd0);
        seen = 1'b0;
        for (int c = 0; c < 200; c++) begin
            if (pixel_we) npix++;
            if (line_done) begin
                seen = 1'b1;
                break;
            end
            @(negedge clk);
        end
        chk("long_done_seen", {31'd0, seen}, 32'd1);
        chk("long_npix", 32'(npix), 32'd100);
        @(negedge clk);
        chk("full_ready_pop", {31'd0, cmd_if.cmd_ready}, 32'd0);
        expect_line(q[0], 1'b0, 1'b1);
        for (int j = 1; j < 4; j++) expect_line(q[j], 1'b0, 1'b0);
        chk("fifo_drain_busy", {31'd0, busy}, 32'd0);
        chk("fifo_drain_we", {31'd0, pixel_we}, 32'd0);

        // Push coincident with the IDLE pop of a single queued entry
        va = mk(1, 2, 3, 2, 4, 3);
        vb = mk(5, 7, 5, 7, 6, 1);
        drive_cmd(va, 1'b1);
        @(negedge clk);
        drive_cmd(vb, 1'b1);
        chk("pp_ready", {31'd0, cmd_if.cmd_ready}, 32'd1);
        expect_line(va, 1'b0, 1'b0);
        expect_line(vb, 1'b0, 1'b0);
        repeat (4) begin
            chk("pp_idle_we", {31'd0, pixel_we}, 32'd0);
            chk("pp_idle_busy", {31'd0, busy}, 32'd0);
            @(negedge clk);
        end

        // Reset during pixel 2 with two commands queued
        lm = mk(0, 0, 9, 0, 2, 10);
        m1 = mk(30, 1, 31, 1, 1, 2);
        m2 = mk(40, 2, 41, 2, 5, 2);
        drive_cmd(lm, 1'b1);
        @(negedge clk);
        drive_cmd(m1, 1'b1);
        @(negedge clk);
        drive_cmd(m2, 1'b1);
        @(negedge clk);
        cmd_if.cmd_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("mid_pix2_we", {31'd0, pixel_we}, 32'd1);
        chk("mid_pix2_x", {21'd0, pixel_x}, 32'd2);
        #2 reset = 1'b0;
        #1;
        chk("mid_rst_we", {31'd0, pixel_we}, 32'd0);
        chk("mid_rst_done", {31'd0, line_done}, 32'd0);
        chk("mid_rst_busy", {31'd0, busy}, 32'd0);
        chk("mid_rst_ldrst", {31'd0, ld_reset}, 32'd1);
        chk("mid_rst_ready", {31'd0, cmd_if.cmd_ready}, 32'd1);
        chk("mid_rst_x1", {21'd0, ld_x1}, 32'd0);
        chk("mid_rst_col", {29'd0, pixel_color}, 32'd0);
        @(negedge clk);
        reset = 1'b1;
        repeat (6) begin
            @(negedge clk);
            chk("mid_after_we", {31'd0, pixel_we}, 32'd0);
            chk("mid_after_busy", {31'd0, busy}, 32'd0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/line_cmd_sequencer.md
# line_cmd_sequencer

Command-side front end for `line_drawer`. It accepts line-draw commands (two endpoints plus a colour) over a valid/ready interface and buffers them in a small FIFO. For each command it sequences the drawer's `reset`/endpoint inputs and counts the drawer's output pixels, emitting exactly one pixel-write strobe per pixel toward the framebuffer. It detects line completion by counting pixels, never by comparing endpoints. This is necessary because the drawer may traverse a line in either direction.

## Interface
Parameters:
- `DEPTH`, 4: command FIFO entries (power of 2, ≥2).
- `CW`, 3: colour width in bits.

Ports:
- `clk` in 1: system clock, all state on rising edge.
- `reset` in 1: asynchronous, active-low. Low clears all state immediately.
- `cmd_valid` in 1: command present.
- `cmd_ready` out 1: FIFO can accept; equals !full.
- `cmd_x0`, `cmd_y0`, `cmd_x1`, `cmd_y1` in 11 each: line endpoints.
- `cmd_color` in CW: pixel colour for the line.
- `ld_reset` out 1: drives line_drawer `reset` (active-high).
- `ld_x0`, `ld_y0`, `ld_x1`, `ld_y1` out 11 each: drive line_drawer endpoints.
- `ld_x`, `ld_y` in 11 each: line_drawer pixel outputs.
- `pixel_x`, `pixel_y` out 11 each: framebuffer write address.
- `pixel_color` out CW: framebuffer write data.
- `pixel_we` out 1: framebuffer write strobe, one pixel per high cycle.
- `line_done` out 1: single-cycle pulse on the last pixel of a line.
- `busy` out 1: high when state != IDLE or the FIFO is non-empty.

## Operation
- **FIFO:** `DEPTH` entries, each 44+CW bits. A push occurs on `cmd_valid && cmd_ready`. Pop is internal. Push and pop may occur in the same cycle. `cmd_ready` depends only on full, so there is no push-when-full. Order is preserved.
- **Working registers** (`wx0`, `wy0`, `wx1`, `wy1`, `wcol`) are loaded on pop. They drive `ld_*` and `pixel_color`, and are held stable until the next pop.
- **Pixel count:** on pop, `cnt <= max(|x1-x0|, |y1-y0|)` (11-bit unsigned, using unsigned abs-diff). This equals N−1, where N is the pixel count.
- **FSM states:**
  - IDLE:
    - `ld_reset`=1, `pixel_we`=0.
    - If FIFO non-empty: pop, load working registers and `cnt`, go to LOAD.
  - LOAD:
    - `ld_reset`=1 for exactly one cycle, with endpoints valid.
    - Go to DRAW.
  - DRAW:
    - `ld_reset`=0, `pixel_we`=1, `pixel_x`=`ld_x`, `pixel_y`=`ld_y`.
    - If `cnt`==0: `line_done`=1, go to IDLE.
    - Else: `cnt <= cnt-1`.
- `pixel_x`/`pixel_y` pass `ld_x`/`ld_y` through combinationally. Their value is don't-care while `pixel_we`=0.
- No backpressure exists on the pixel side: the drawer cannot stall, so the framebuffer must accept one write per cycle.
- **Degenerate point line** (x0=x1, y0=y1): N=1, a single DRAW cycle with `line_done` high.
- **Async reset low, including mid-line:**
  - State returns to IDLE and the FIFO is emptied (pointers and count 0).
  - `cnt`=0 and working registers are 0.
  - Outputs: `pixel_we`=0, `line_done`=0, `busy`=0, `ld_reset`=1, `cmd_ready`=1, `ld_*` endpoints 0, `pixel_color` 0.
  - Any partially drawn line is abandoned.

## Timing
- Command accepted at edge E:
  - FIFO non-empty during cycle E+1, when IDLE pops.
  - LOAD during cycle E+2.
  - First `pixel_we` during cycle E+3.
- A line of N pixels occupies 1 IDLE + 1 LOAD + N DRAW cycles, so back-to-back lines have a 2-cycle gap.
- `line_done` coincides with the last `pixel_we`.
- `busy` drops in the cycle after the last DRAW if the FIFO is empty.
- `cmd_ready` rises in the cycle after a pop from a full FIFO.

## Test plan
1. **Reset:** hold `reset`=0 with random inputs → `pixel_we`=0, `line_done`=0, `busy`=0, `cmd_ready`=1, `ld_reset`=1. Deassert → still idle.
2. **Horizontal line:** push (0,0)→(3,0), colour 5, at edge E → `pixel_we` high cycles E+3..E+6 with (x,y) = (0,0),(1,0),(2,0),(3,0) and colour 5. `line_done` only at E+6. `busy` low at E+7.
3. **Reversed diagonal:** (3,3)→(0,0) → exactly 4 writes (0,0),(1,1),(2,2),(3,3). Steep (0,0)→(2,5) → exactly 6 writes (0,0),(1,1),(1,2),(1,3),(2,4),(2,5). Point line (6,6)→(6,6) → 1 write with `line_done`.
4. **FIFO full:** while a 100-pixel line draws, present `cmd_valid` continuously → exactly 4 accepts, then `cmd_ready`=0. `cmd_ready` returns to 1 one cycle after the next pop. Lines are drawn in push order with a 2-cycle gap between them.
5. **Simultaneous push/pop:** push exactly at the IDLE pop cycle with one entry queued → no entry lost or duplicated, and the FIFO count is unchanged.
6. **Mid-line reset:** assert `reset`=0 during pixel 2 of (0,0)→(9,0) with 2 commands queued → `pixel_we` drops immediately. After release, no pixels are written and `busy`=0.
